// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle MIPS-style controller: states, opcodes,
// funct codes, ALU operations and datapath mux selects.
package multicycle_control_pkg;

    localparam int unsigned OPCODE_W   = 6;
    localparam int unsigned FUNCT_W    = 6;
    localparam int unsigned ALU_CTRL_W = 3;
    localparam int unsigned SEL_W      = 2;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMRD,
        MEMWB,
        MEMWR,
        RTYPE_EX,
        RTYPE_WB,
        BEQ_EX,
        ADDI_EX,
        ADDI_WB,
        JUMP,
        HALT
    } state_t;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'h02;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'h23;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'h2B;

    localparam logic [FUNCT_W-1:0] FN_ADD = 6'h20;
    localparam logic [FUNCT_W-1:0] FN_SUB = 6'h22;
    localparam logic [FUNCT_W-1:0] FN_AND = 6'h24;
    localparam logic [FUNCT_W-1:0] FN_OR  = 6'h25;
    localparam logic [FUNCT_W-1:0] FN_SLT = 6'h2A;

    // Must match the ALU's operation encoding
    localparam logic [ALU_CTRL_W-1:0] ALU_AND = 3'b000;
    localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 3'b001;
    localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 3'b010;
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 3'b011;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLT = 3'b100;

    localparam logic [SEL_W-1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [SEL_W-1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [SEL_W-1:0] PC_SRC_JUMP   = 2'b10;

    localparam logic [SEL_W-1:0] SRCB_REG  = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_FOUR = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_IMM  = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// R-type funct to ALU operation decode; valid=0 flags an unsupported funct.
module alu_decoder
    import multicycle_control_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alu_control,
    output logic       valid
);

    always_comb begin
        alu_control = ALU_ADD;
        valid       = 1'b1;
        case (funct)
            FN_ADD:  alu_control = ALU_ADD;
            FN_SUB:  alu_control = ALU_SUB;
            FN_AND:  alu_control = ALU_AND;
            FN_OR:   alu_control = ALU_OR;
            FN_SLT:  alu_control = ALU_SLT;
            default: valid       = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle controller FSM with memory-wait timeout and sticky fault/HALT.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       retire,
    output logic       fault
);

    localparam int unsigned CNT_W = 8;

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   wait_cnt;
    logic               fault_q;
    logic [2:0]         rtype_alu_ctrl;
    logic               funct_valid;
    logic               waiting_c;
    logic               timeout_c;

    alu_decoder u_alu_decoder (
        .funct       (funct),
        .alu_control (rtype_alu_ctrl),
        .valid       (funct_valid)
    );

    // A wait cycle is any memory-state cycle without mem_ready
    always_comb begin
        waiting_c = ((state == FETCH) || (state == MEMRD) || (state == MEMWR)) && !mem_ready;
        timeout_c = waiting_c && (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= FETCH;
            wait_cnt <= '0;
            fault_q  <= 1'b0;
        end else begin
            state    <= next_state;
            wait_cnt <= waiting_c ? wait_cnt + CNT_W'(1) : '0;
            if (next_state == HALT) begin
                fault_q <= 1'b1;
            end
        end
    end

    always_comb begin
        next_state  = state;
        mem_req     = 1'b0;
        mem_write   = 1'b0;
        iord        = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_src      = PC_SRC_ALU;
        alu_src_a   = 1'b0;
        alu_src_b   = SRCB_REG;
        alu_control = ALU_ADD;
        reg_write   = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        retire      = 1'b0;
        fault       = fault_q;

        case (state)
            FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = SRCB_FOUR;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    next_state = DECODE;
                end else if (timeout_c) begin
                    next_state = HALT;
                end
            end
            DECODE: begin
                alu_src_b = SRCB_IMM;
                case (opcode)
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_RTYPE:     next_state = RTYPE_EX;
                    OP_BEQ:       next_state = BEQ_EX;
                    OP_ADDI:      next_state = ADDI_EX;
                    OP_J:         next_state = JUMP;
                    default:      next_state = HALT;
                endcase
            end
            MEMADR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_IMM;
                next_state = (opcode == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready) begin
                    next_state = MEMWB;
                end else if (timeout_c) begin
                    next_state = HALT;
                end
            end
            MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
                next_state = FETCH;
            end
            MEMWR: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ready) begin
                    retire     = 1'b1;
                    next_state = FETCH;
                end else if (timeout_c) begin
                    next_state = HALT;
                end
            end
            RTYPE_EX: begin
                alu_src_a   = 1'b1;
                alu_control = rtype_alu_ctrl;
                next_state  = funct_valid ? RTYPE_WB : HALT;
            end
            RTYPE_WB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                retire     = 1'b1;
                next_state = FETCH;
            end
            BEQ_EX: begin
                alu_src_a   = 1'b1;
                alu_control = ALU_SUB;
                pc_src      = PC_SRC_ALUOUT;
                pc_write    = zero;
                retire      = 1'b1;
                next_state  = FETCH;
            end
            ADDI_EX: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_IMM;
                next_state = ADDI_WB;
            end
            ADDI_WB: begin
                reg_write  = 1'b1;
                retire     = 1'b1;
                next_state = FETCH;
            end
            JUMP: begin
                pc_write   = 1'b1;
                pc_src     = PC_SRC_JUMP;
                retire     = 1'b1;
                next_state = FETCH;
            end
            HALT: begin
                next_state = HALT;
            end
            default: begin
                next_state = HALT;
            end
        endcase

        // Everything is quiet while reset is being applied
        if (!rst_n) begin
            mem_req   = 1'b0;
            mem_write = 1'b0;
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            reg_write = 1'b0;
            retire    = 1'b0;
            fault     = 1'b0;
        end
    end

endmodule
